// File: rtl/config_mem_loader_if.sv
// config_mem_loader_if
//   Bundles the config-packet link from the router and the three config memory
//   write ports driven by the loader.
//   Link:    cfgData_i / cfgValid_i (router -> loader), cfgReady_o (loader -> router)
//   Control: errClr_i clears the sticky err_o; busy_o is high while a packet is in flight
//   Mem A:   wrEn_A_o, wrAddr_A_o, wrData_A_o  (STDP parameters)
//   Mem B:   wrEn_B_o, wrAddr_B_o, wrData_B_o  (neuron parameters)
//   Mem C:   wrEn_C_o, wrAddr_C_o, wrData_C_o  (per-axon learn mode bit)
//   Modports: master = router/environment side, slave = loader side.
interface config_mem_loader_if #(
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32
);
    localparam int WA     = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
    localparam int WB     = 2 + 2*DSIZE + AER_BIT_WIDTH;
    localparam int ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

    logic [AER_BIT_WIDTH-1:0]      cfgData_i;
    logic                          cfgValid_i;
    logic                          cfgReady_o;
    logic                          errClr_i;
    logic                          wrEn_A_o;
    logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_A_o;
    logic [WA-1:0]                 wrData_A_o;
    logic                          wrEn_B_o;
    logic [NURN_CNT_BIT_WIDTH-1:0] wrAddr_B_o;
    logic [WB-1:0]                 wrData_B_o;
    logic                          wrEn_C_o;
    logic [ADDR_W-1:0]             wrAddr_C_o;
    logic                          wrData_C_o;
    logic                          busy_o;
    logic                          err_o;

    modport master (
        output cfgData_i, cfgValid_i, errClr_i,
        input  cfgReady_o, busy_o, err_o,
        input  wrEn_A_o, wrAddr_A_o, wrData_A_o,
        input  wrEn_B_o, wrAddr_B_o, wrData_B_o,
        input  wrEn_C_o, wrAddr_C_o, wrData_C_o
    );

    modport slave (
        input  cfgData_i, cfgValid_i, errClr_i,
        output cfgReady_o, busy_o, err_o,
        output wrEn_A_o, wrAddr_A_o, wrData_A_o,
        output wrEn_B_o, wrAddr_B_o, wrData_B_o,
        output wrEn_C_o, wrAddr_C_o, wrData_C_o
    );
endinterface

// File: rtl/config_mem_loader.sv
// config_mem_loader
//   Runtime loader for the neuron config memories. Takes a header beat plus
//   NBEAT_x data beats over a valid/ready link, assembles them into one memory
//   word and issues a single one-cycle write to memory A, B or C.
//   Ports:
//     clk_i  clock
//     rst_i  asynchronous reset, active-high
//     cfg    config_mem_loader_if.slave (packet link, error control, write ports)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a header beat; ready high
//   DATA  | collecting data beats of the current packet; ready high
//   WRITE | one cycle with the selected write strobe high; ready low
module config_mem_loader #(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    config_mem_loader_if.slave cfg
);
    localparam int ADDR_W    = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int WA        = 2*STDP_WIN_BIT_WIDTH + 2*DSIZE + 1;
    localparam int WB        = 2 + 2*DSIZE + AER_BIT_WIDTH;
    localparam int NBEAT_A   = (WA + AER_BIT_WIDTH - 1) / AER_BIT_WIDTH;
    localparam int NBEAT_B   = (WB + AER_BIT_WIDTH - 1) / AER_BIT_WIDTH;
    localparam int NBEAT_MAX = (NBEAT_A > NBEAT_B) ? NBEAT_A : NBEAT_B;
    localparam int ASM_W     = NBEAT_MAX * AER_BIT_WIDTH;
    localparam int CNT_W     = $clog2(NBEAT_MAX + 1);

    // One extra bit so NUM_NURNS*NUM_AXONS itself is representable.
    localparam logic [ADDR_W:0] NURN_LIMIT = (ADDR_W+1)'(NUM_NURNS);
    localparam logic [ADDR_W:0] C_LIMIT    = (ADDR_W+1)'(NUM_NURNS * NUM_AXONS);

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_R = 2'd3;

    typedef enum logic [1:0] {IDLE, DATA, WRITE} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    sel_q, sel_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          rng_err_q, rng_err_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [ASM_W-1:0]              asm_q, asm_d;
    logic                          ready_q, ready_d;
    logic                          busy_q, busy_d;
    logic                          err_q, err_d;
    logic                          wr_en_a_q, wr_en_a_d;
    logic                          wr_en_b_q, wr_en_b_d;
    logic                          wr_en_c_q, wr_en_c_d;
    logic [NURN_CNT_BIT_WIDTH-1:0] wr_addr_a_q, wr_addr_a_d;
    logic [NURN_CNT_BIT_WIDTH-1:0] wr_addr_b_q, wr_addr_b_d;
    logic [ADDR_W-1:0]             wr_addr_c_q, wr_addr_c_d;
    logic [WA-1:0]                 wr_data_a_q, wr_data_a_d;
    logic [WB-1:0]                 wr_data_b_q, wr_data_b_d;
    logic                          wr_data_c_q, wr_data_c_d;

    logic                          xfer;
    logic [1:0]                    hdr_sel;
    logic [ADDR_W-1:0]             hdr_addr;
    logic                          hdr_ab_bad;
    logic                          hdr_c_bad;
    logic [CNT_W-1:0]              last_idx;
    logic                          set_err;
    logic                          unused_asm;

    assign xfer     = cfg.cfgValid_i & ready_q;
    assign hdr_sel  = cfg.cfgData_i[AER_BIT_WIDTH-1 -: 2];
    assign hdr_addr = cfg.cfgData_i[ADDR_W-1:0];

    // A/B only use the neuron field; any axon-field bit makes the header invalid.
    assign hdr_ab_bad = (hdr_addr[ADDR_W-1:NURN_CNT_BIT_WIDTH] != '0) ||
                        ({1'b0, hdr_addr} >= NURN_LIMIT);
    assign hdr_c_bad  = ({1'b0, hdr_addr} >= C_LIMIT);

    // Top assembly bits beyond WB never reach a memory port.
    assign unused_asm = ^asm_q;

    always_comb begin
        case (sel_q)
            SEL_A:   last_idx = CNT_W'(NBEAT_A - 1);
            SEL_B:   last_idx = CNT_W'(NBEAT_B - 1);
            default: last_idx = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        rng_err_d   = rng_err_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        wr_en_a_d   = 1'b0;
        wr_en_b_d   = 1'b0;
        wr_en_c_d   = 1'b0;
        wr_addr_a_d = wr_addr_a_q;
        wr_addr_b_d = wr_addr_b_q;
        wr_addr_c_d = wr_addr_c_q;
        wr_data_a_d = wr_data_a_q;
        wr_data_b_d = wr_data_b_q;
        wr_data_c_d = wr_data_c_q;
        set_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_sel == SEL_R) begin
                        set_err = 1'b1;
                    end else begin
                        sel_d     = hdr_sel;
                        addr_d    = hdr_addr;
                        cnt_d     = '0;
                        asm_d     = '0;
                        rng_err_d = (hdr_sel == SEL_C) ? hdr_c_bad : hdr_ab_bad;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    for (int i = 0; i < NBEAT_MAX; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            asm_d[i*AER_BIT_WIDTH +: AER_BIT_WIDTH] = cfg.cfgData_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == last_idx) begin
                        state_d = WRITE;
                        // Strobes are registered here so they sit high in the WRITE cycle.
                        if (rng_err_q) begin
                            set_err = 1'b1;
                        end else begin
                            case (sel_q)
                                SEL_A: begin
                                    wr_en_a_d   = 1'b1;
                                    wr_addr_a_d = addr_q[NURN_CNT_BIT_WIDTH-1:0];
                                    wr_data_a_d = asm_d[WA-1:0];
                                end
                                SEL_B: begin
                                    wr_en_b_d   = 1'b1;
                                    wr_addr_b_d = addr_q[NURN_CNT_BIT_WIDTH-1:0];
                                    wr_data_b_d = asm_d[WB-1:0];
                                end
                                default: begin
                                    wr_en_c_d   = 1'b1;
                                    wr_addr_c_d = addr_q;
                                    wr_data_c_d = asm_d[0];
                                end
                            endcase
                        end
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != WRITE);
        busy_d  = (state_d != IDLE);
        // A set in the same cycle as a clear wins.
        err_d   = set_err ? 1'b1 : (cfg.errClr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            rng_err_q   <= 1'b0;
            cnt_q       <= '0;
            asm_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_en_a_q   <= 1'b0;
            wr_en_b_q   <= 1'b0;
            wr_en_c_q   <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_addr_c_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
            wr_data_c_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            rng_err_q   <= rng_err_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            wr_en_a_q   <= wr_en_a_d;
            wr_en_b_q   <= wr_en_b_d;
            wr_en_c_q   <= wr_en_c_d;
            wr_addr_a_q <= wr_addr_a_d;
            wr_addr_b_q <= wr_addr_b_d;
            wr_addr_c_q <= wr_addr_c_d;
            wr_data_a_q <= wr_data_a_d;
            wr_data_b_q <= wr_data_b_d;
            wr_data_c_q <= wr_data_c_d;
        end
    end

    assign cfg.cfgReady_o = ready_q;
    assign cfg.busy_o     = busy_q;
    assign cfg.err_o      = err_q;
    assign cfg.wrEn_A_o   = wr_en_a_q;
    assign cfg.wrAddr_A_o = wr_addr_a_q;
    assign cfg.wrData_A_o = wr_data_a_q;
    assign cfg.wrEn_B_o   = wr_en_b_q;
    assign cfg.wrAddr_B_o = wr_addr_b_q;
    assign cfg.wrData_B_o = wr_data_b_q;
    assign cfg.wrEn_C_o   = wr_en_c_q;
    assign cfg.wrAddr_C_o = wr_addr_c_q;
    assign cfg.wrData_C_o = wr_data_c_q;
endmodule

// File: tb/tb_config_mem_loader.sv
// tb_config_mem_loader
//   Drives directed and random config packets into config_mem_loader and compares
//   every memory write and the error flag against a packet-level reference model.
module tb_config_mem_loader;
    localparam int NURNS = 200;
    localparam int AXONS = 256;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [65:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   err_m = 1'b0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    wr_t  last_wr;
    wr_t  mon_w;
    int   mon_n;

    config_mem_loader_if bus();

    config_mem_loader #(.NUM_NURNS(NURNS), .NUM_AXONS(AXONS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cfg   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Observes write strobes away from the clock edge.
    always @(negedge clk) begin
        mon_n = int'(bus.wrEn_A_o) + int'(bus.wrEn_B_o) + int'(bus.wrEn_C_o);
        if (mon_n > 0) begin
            chk("wr_onehot", mon_n, 1);
            mon_w.cyc = cyc;
            if (bus.wrEn_A_o) begin
                mon_w.kind = 0; mon_w.addr = {8'd0, bus.wrAddr_A_o}; mon_w.data = {17'd0, bus.wrData_A_o};
            end else if (bus.wrEn_B_o) begin
                mon_w.kind = 1; mon_w.addr = {8'd0, bus.wrAddr_B_o}; mon_w.data = bus.wrData_B_o;
            end else begin
                mon_w.kind = 2; mon_w.addr = bus.wrAddr_C_o; mon_w.data = {65'd0, bus.wrData_C_o};
            end
            obs_q.push_back(mon_w);
            last_wr = mon_w;
        end
    end

    // Called and returns at a negedge; the beat transfers at the posedge in between.
    task automatic send_beat(input logic [31:0] d);
        int n;
        n = 0;
        bus.cfgValid_i = 1'b1;
        bus.cfgData_i  = d;
        while (!bus.cfgReady_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 0, 1);
        @(negedge clk);
        bus.cfgValid_i = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] sel, input logic [15:0] addr,
                            input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                            input int gap_after, input int gap_len);
        int          nb;
        logic [95:0] w;
        wr_t         e;
        bit          bad;
        nb = (sel == 2'd0) ? 2 : (sel == 2'd1) ? 3 : (sel == 2'd2) ? 1 : 0;
        e.cyc = 0;
        send_beat({sel, 14'd0, addr});
        for (int i = 0; i < nb; i++) begin
            send_beat(i == 0 ? b0 : (i == 1 ? b1 : b2));
            if (i == nb - 1) e.cyc = cyc;
            else if (i == gap_after) repeat (gap_len) @(negedge clk);
        end
        w = {b2, b1, b0};
        if (sel == 2'd3)      bad = 1'b1;
        else if (sel == 2'd2) bad = (int'(addr) >= NURNS * AXONS);
        else                  bad = (int'(addr) >= NURNS);
        if (bad) begin
            err_m = 1'b1;
        end else begin
            e.kind = int'(sel);
            e.addr = addr;
            if (sel == 2'd0)      e.data = {17'd0, w[48:0]};
            else if (sel == 2'd1) e.data = w[65:0];
            else                  e.data = {65'd0, b0[0]};
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        wr_t e;
        wr_t o;
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_kind"}, o.kind, e.kind);
            chk({tag, "_addr"}, o.addr, e.addr);
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_cyc"},  o.cyc,  e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
        chk({tag, "_err"}, bus.err_o, err_m);
    endtask

    task automatic err_clear();
        bus.errClr_i = 1'b1;
        @(negedge clk);
        bus.errClr_i = 1'b0;
        err_m = 1'b0;
        chk("errclr", bus.err_o, 0);
    endtask

    initial begin
        logic [1:0]  sel;
        logic [15:0] addr;
        int          r;
        last_wr.kind = -1;
        bus.cfgValid_i = 1'b0;
        bus.cfgData_i  = '0;
        bus.errClr_i   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", bus.cfgReady_o, 0);
        chk("rst_busy",  bus.busy_o, 0);
        chk("rst_err",   bus.err_o, 0);
        chk("rst_wren",  {bus.wrEn_A_o, bus.wrEn_B_o, bus.wrEn_C_o}, 0);
        chk("rst_addrc", bus.wrAddr_C_o, 0);
        chk("rst_datab", bus.wrData_B_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", bus.cfgReady_o, 1);
        chk("rel_busy",  bus.busy_o, 0);

        // A write with exact latency; ready drops during the write cycle.
        send_pkt(2'd0, 16'd5, 32'h89AB_CDEF, 32'h0001_1234, 32'h0, -1, 0);
        chk("t1_ready_wr", bus.cfgReady_o, 0);
        chk("t1_busy_wr",  bus.busy_o, 1);
        drain("t1");
        chk("t1_kind", last_wr.kind, 0);
        chk("t1_addr", last_wr.addr, 16'd5);
        chk("t1_data", last_wr.data, 66'h1_1234_89AB_CDEF);

        // B write with valid low for 4 cycles mid-packet.
        send_pkt(2'd1, 16'd17, 32'h1111_2222, 32'h3333_4444, 32'h0000_0003, 0, 4);
        drain("t2");
        chk("t2_data", last_wr.data, 66'h3_3333_4444_1111_2222);

        // C write.
        send_pkt(2'd2, 16'h03C8, 32'h1, 32'h0, 32'h0, -1, 0);
        drain("t3");
        chk("t3_addr", last_wr.addr, 16'h03C8);
        chk("t3_data", last_wr.data, 66'd1);

        // Reserved select, then a good packet, then clear.
        send_pkt(2'd3, 16'd9, 32'h0, 32'h0, 32'h0, -1, 0);
        drain("t4a");
        send_pkt(2'd0, 16'd77, $urandom, $urandom, 32'h0, -1, 0);
        drain("t4b");
        err_clear();

        // Range boundaries with NUM_NURNS=200.
        send_pkt(2'd0, 16'd200, $urandom, $urandom, 32'h0, -1, 0);
        drain("t5_a200");
        err_clear();
        send_pkt(2'd1, 16'h0105, $urandom, $urandom, $urandom, -1, 0);
        drain("t5_bhi");
        err_clear();
        send_pkt(2'd0, 16'd199, $urandom, $urandom, 32'h0, -1, 0);
        drain("t5_a199");
        send_pkt(2'd2, 16'd51200, 32'h1, 32'h0, 32'h0, -1, 0);
        drain("t5_c51200");
        err_clear();
        send_pkt(2'd2, 16'd51199, 32'h1, 32'h0, 32'h0, -1, 0);
        drain("t5_c51199");

        // Error set wins over a simultaneous clear.
        bus.errClr_i = 1'b1;
        send_beat({2'b11, 30'd0});
        chk("setwin_err", bus.err_o, 1);
        @(negedge clk);
        chk("setwin_clr", bus.err_o, 0);
        bus.errClr_i = 1'b0;
        err_m = 1'b0;

        // Reset mid-packet.
        send_beat({2'b01, 14'd0, 16'd10});
        send_beat($urandom);
        chk("t6_busy", bus.busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_ready", bus.cfgReady_o, 0);
        chk("t6_rbusy", bus.busy_o, 0);
        chk("t6_wren",  {bus.wrEn_A_o, bus.wrEn_B_o, bus.wrEn_C_o}, 0);
        chk("t6_addra", bus.wrAddr_A_o, 0);
        chk("t6_addrc", bus.wrAddr_C_o, 0);
        chk("t6_dataa", bus.wrData_A_o, 0);
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        @(negedge clk);
        chk("t6_rel_ready", bus.cfgReady_o, 1);
        send_pkt(2'd0, 16'd33, 32'hDEAD_BEEF, 32'h0000_ACE1, 32'h0, -1, 0);
        drain("t6");

        // Random packets.
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            sel = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 99) < 85)
                addr = (sel == 2'd2) ? 16'($urandom_range(0, NURNS*AXONS - 1))
                                     : 16'($urandom_range(0, NURNS - 1));
            else
                addr = (sel == 2'd2) ? 16'($urandom_range(NURNS*AXONS, 65535))
                                     : 16'($urandom_range(NURNS, 65535));
            send_pkt(sel, addr, $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            drain("rnd");
            if ($urandom_range(0, 3) == 0) err_clear();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
